keypad_scanner: RTL

Matrix keypad scanner and debouncer for the calculator front end. Scans a 4x4 key matrix one column at a time and debounces each key over whole scan frames. For each debounced press it emits a 4-bit key code with a single-cycle enable strobe. The strobe is the writer side of the key data latch: key_code drives the latch data input, and key_en drives its enable.

---
 rtl/calc_keypad_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/keypad_scanner.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/calc_keypad_pkg.sv
// Shared types and helpers for the calculator keypad front end.
package calc_keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  typedef enum logic [1:0] {IDLE, CONFIRM, PRESSED, RELEASE} state_e;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_e;

  // Number of low (pressed) rows in one column sample.
  function automatic logic [2:0] count_low(input logic [NUM_ROWS-1:0] rows);
    logic [2:0] n;
    n = 3'd0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!rows[r]) n = n + 3'd1;
    end
    return n;
  endfunction

  // Running low-bit count saturating at 2; that is all MULTI detection needs.
  function automatic logic [1:0] sat_add2(input logic [1:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {2'b00, a} + {1'b0, b};
    return (s >= 4'd2) ? 2'd2 : s[1:0];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; 2-cycle latency, per-bit reset value.
module sync_2ff #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      q_o    <= RST_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with frame-based debounce; one-cycle key_en per accepted press.
// Outputs change on the edge that closes a 4*SCAN_DIV-cycle frame; no backpressure.
module keypad_scanner
  import calc_keypad_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic [KEY_W-1:0]    key_code,
  output logic             key_en,
  output logic             key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = ($clog2(DEBOUNCE + 1) < 2) ? 2 : $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEB  = CNT_W'(DEBOUNCE);

  logic [NUM_ROWS-1:0] rows_s;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [1:0]          col_q, col_d;
  logic [1:0]          accn_q, accn_d;
  logic [KEY_W-1:0]    accc_q, accc_d;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [KEY_W-1:0]    cand_q, cand_d;
  logic [KEY_W-1:0]    code_q, code_d;
  logic                en_q, en_d;

  logic                sample, close;
  logic [2:0]          col_n;
  logic [1:0]          row_sel;
  logic [1:0]          frame_n;
  logic [KEY_W-1:0]    frame_code;
  frame_e              fclass;
  logic [CNT_W-1:0]    cnt_inc;

  sync_2ff #(.WIDTH(NUM_ROWS), .RST_VAL({NUM_ROWS{1'b1}})) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (row_in),
    .q_o (rows_s)
  );

  assign sample = (div_q == DIV_LAST);
  assign close  = sample && (col_q == 2'd3);

  // Fold the current column into the frame so the column-3 sample classifies on the same edge.
  always_comb begin
    col_n   = count_low(rows_s);
    row_sel = 2'd0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!rows_s[r]) row_sel = 2'(r);
    end
    frame_n    = sat_add2(accn_q, col_n);
    frame_code = (col_n != 3'd0) ? {row_sel, col_q} : accc_q;
    case (frame_n)
      2'd0:    fclass = NONE;
      2'd1:    fclass = SINGLE;
      default: fclass = MULTI;
    endcase
  end

  always_comb begin
    div_d  = sample ? '0 : div_q + DIV_W'(1);
    col_d  = sample ? col_q + 2'd1 : col_q;
    accn_d = accn_q;
    accc_d = accc_q;
    if (sample) begin
      accn_d = close ? 2'd0 : frame_n;
      accc_d = close ? '0 : frame_code;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    en_d    = 1'b0;
    cnt_inc = cnt_q + CNT_ONE;
    if (close) begin
      case (state_q)
        IDLE: if (fclass == SINGLE) begin
          cand_d = frame_code;
          cnt_d  = CNT_ONE;
          if (DEBOUNCE == 1) begin
            state_d = PRESSED;
            code_d  = frame_code;
            en_d    = 1'b1;
          end else begin
            state_d = CONFIRM;
          end
        end
        CONFIRM: begin
          if (fclass != SINGLE) begin
            state_d = IDLE;
          end else if (frame_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DEB) begin
              state_d = PRESSED;
              code_d  = cand_q;
              en_d    = 1'b1;
            end
          end else begin
            cand_d = frame_code;
            cnt_d  = CNT_ONE;
          end
        end
        PRESSED: if (fclass == NONE) begin
          cnt_d   = CNT_ONE;
          state_d = (DEBOUNCE == 1) ? IDLE : RELEASE;
        end
        RELEASE: begin
          if (fclass != NONE) begin
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DEB) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      col_q   <= 2'd0;
      accn_q  <= 2'd0;
      accc_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      col_q   <= col_d;
      accn_q  <= accn_d;
      accc_q  <= accc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      en_q    <= en_d;
    end
  end

  assign col_out  = ~(4'b0001 << col_q);
  assign key_code = code_q;
  assign key_en   = en_q;
  assign key_held = (state_q == PRESSED) || (state_q == RELEASE);

endmodule
